// File: rtl/rti_pkg.sv
// Shared RTI definitions: entry layout, default widths and the dispatcher
// state encoding. Producers on the RTI core side use rti_entry_t, so the
// timestamp-in-upper-half layout must not change here without them.
package rti_pkg;

  localparam int RTI_ENTRY_W = 128;
  localparam int RTI_TS_W    = 64;
  localparam int RTI_DATA_W  = 64;
  localparam int RTI_CNT_W   = 32;

  // State table
  //   state | meaning
  //   IDLE  | nothing held; may pop the FIFO
  //   LOAD  | pop issued last cycle; capture fifo_dout this cycle
  //   ARMED | entry held; waiting for counter to reach its timestamp
  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    LOAD  = 2'd1,
    ARMED = 2'd2
  } rti_disp_state_t;

  typedef struct packed {
    logic [RTI_TS_W-1:0]   ts;
    logic [RTI_DATA_W-1:0] data;
  } rti_entry_t;

  // Builds an entry in the layout the RTI core stores.
  function automatic rti_entry_t rti_make_entry(input logic [RTI_TS_W-1:0]   ts,
                                                input logic [RTI_DATA_W-1:0] data);
    rti_entry_t e;
    e.ts   = ts;
    e.data = data;
    return e;
  endfunction

endpackage

// File: rtl/rti_ts_compare.sv
// Unsigned full-width compare of the system timer against the held timestamp.
// Kept as its own block so it can be pipelined later without touching the FSM.
module rti_ts_compare #(
  parameter int W = 64
) (
  input  logic [W-1:0] i_counter,
  input  logic [W-1:0] i_hold_ts,
  output logic         o_eq,
  output logic         o_gt
);

  assign o_eq = (i_counter == i_hold_ts);
  assign o_gt = (i_counter >  i_hold_ts);

endmodule

// File: rtl/rti_dispatcher.sv
// RTI dispatcher: pops timed entries from the RTI core FIFO, holds each one
// until the system timer equals its timestamp, then issues the payload as a
// one-cycle strobe. Entries already in the past raise timing_error.
//
// Build option RTI_DISPATCH_DROP_LATE_EN:
//   undefined - a late entry is issued anyway, together with timing_error
//   defined   - a late entry is discarded and counted on drop_count
module rti_dispatcher
  import rti_pkg::*;
#(
  parameter int TS_WIDTH    = RTI_TS_W,
  parameter int DATA_WIDTH  = RTI_DATA_W,
  parameter int COUNT_WIDTH = RTI_CNT_W
) (
  input  logic                           clk,
  input  logic                           reset,
  input  logic                           flush,
  input  logic                           enable,
  input  logic [TS_WIDTH-1:0]            counter,
  input  logic [TS_WIDTH+DATA_WIDTH-1:0] fifo_dout,
  input  logic                           fifo_empty,
  output logic                           fifo_read,
  output logic                           out_valid,
  output logic [DATA_WIDTH-1:0]          out_data,
  output logic                           timing_error,
  output logic [TS_WIDTH+DATA_WIDTH-1:0] timing_error_data,
  output logic [COUNT_WIDTH-1:0]         dispatch_count,
`ifdef RTI_DISPATCH_DROP_LATE_EN
  output logic [COUNT_WIDTH-1:0]         drop_count,
`endif
  output logic                           busy
);

  localparam int ENTRY_W = TS_WIDTH + DATA_WIDTH;
  localparam logic [COUNT_WIDTH-1:0] CNT_ONE = COUNT_WIDTH'(1);

  rti_disp_state_t          r_state;
  logic [TS_WIDTH-1:0]      r_hold_ts;
  logic [DATA_WIDTH-1:0]    r_hold_data;
  logic                     r_out_valid;
  logic [DATA_WIDTH-1:0]    r_out_data;
  logic                     r_timing_error;
  logic [ENTRY_W-1:0]       r_timing_error_data;
  logic [COUNT_WIDTH-1:0]   r_dispatch_count;
`ifdef RTI_DISPATCH_DROP_LATE_EN
  logic [COUNT_WIDTH-1:0]   r_drop_count;
`endif

  logic w_clr;
  logic w_eq;
  logic w_gt;
  logic w_done;
  logic w_fetch;

  rti_ts_compare #(
    .W (TS_WIDTH)
  ) u_cmp (
    .i_counter (counter),
    .i_hold_ts (r_hold_ts),
    .o_eq      (w_eq),
    .o_gt      (w_gt)
  );

  // Reset and flush share one clear path; both also block any pop.
  assign w_clr  = reset | flush;
  // The held entry resolves (fires or is found late) this cycle.
  assign w_done = (r_state == ARMED) & (w_eq | w_gt);
  // A pop is allowed from IDLE, or in the same cycle a held entry resolves so
  // back-to-back entries keep the 2-cycle issue spacing.
  assign w_fetch = ~w_clr & enable & ~fifo_empty & ((r_state == IDLE) | w_done);

  assign fifo_read         = w_fetch;
  assign busy              = (r_state == LOAD) | (r_state == ARMED);
  assign out_valid         = r_out_valid;
  assign out_data          = r_out_data;
  assign timing_error      = r_timing_error;
  assign timing_error_data = r_timing_error_data;
  assign dispatch_count    = r_dispatch_count;
`ifdef RTI_DISPATCH_DROP_LATE_EN
  assign drop_count        = r_drop_count;
`endif

  // Dispatch FSM with registered strobes, captured entry and counters.
  always_ff @(posedge clk) begin
    if (w_clr) begin
      r_state             <= IDLE;
      r_hold_ts           <= '0;
      r_hold_data         <= '0;
      r_out_valid         <= 1'b0;
      r_out_data          <= '0;
      r_timing_error      <= 1'b0;
      r_timing_error_data <= '0;
      r_dispatch_count    <= '0;
`ifdef RTI_DISPATCH_DROP_LATE_EN
      r_drop_count        <= '0;
`endif
    end else begin
      r_out_valid    <= 1'b0;
      r_timing_error <= 1'b0;
      case (r_state)
        IDLE: begin
          if (w_fetch) r_state <= LOAD;
        end
        LOAD: begin
          // No compare here: an entry equal to the counter in this cycle is
          // already late by the time it is armed.
          r_hold_ts   <= fifo_dout[ENTRY_W-1 -: TS_WIDTH];
          r_hold_data <= fifo_dout[DATA_WIDTH-1:0];
          r_state     <= ARMED;
        end
        ARMED: begin
          if (w_eq) begin
            r_out_valid      <= 1'b1;
            r_out_data       <= r_hold_data;
            r_dispatch_count <= r_dispatch_count + CNT_ONE;
          end else if (w_gt) begin
            r_timing_error      <= 1'b1;
            r_timing_error_data <= {r_hold_ts, r_hold_data};
`ifdef RTI_DISPATCH_DROP_LATE_EN
            r_drop_count        <= r_drop_count + CNT_ONE;
`else
            r_out_valid         <= 1'b1;
            r_out_data          <= r_hold_data;
            r_dispatch_count    <= r_dispatch_count + CNT_ONE;
`endif
          end
          if (w_done) r_state <= w_fetch ? LOAD : IDLE;
        end
        default: r_state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_rti_dispatcher.sv
// Directed bench for rti_dispatcher with a FIFO model and scoreboards for
// issue strobes and timing errors. Build with or without
// RTI_DISPATCH_DROP_LATE_EN; expectations follow the macro.
module tb_rti_dispatcher;
  import rti_pkg::*;

  localparam int TSW = 64;
  localparam int DW  = 64;
  localparam int CW  = 32;
  localparam int EW  = 128;

  logic           clk = 1'b0;
  logic           reset, flush, enable, fifo_empty;
  logic [TSW-1:0] counter;
  logic [EW-1:0]  fifo_dout;
  logic           fifo_read, out_valid, timing_error, busy;
  logic [DW-1:0]  out_data;
  logic [EW-1:0]  timing_error_data;
  logic [CW-1:0]  dispatch_count;
`ifdef RTI_DISPATCH_DROP_LATE_EN
  logic [CW-1:0]  drop_count;
`endif

  always #5 clk = ~clk;

  rti_dispatcher dut (
    .clk               (clk),
    .reset             (reset),
    .flush             (flush),
    .enable            (enable),
    .counter           (counter),
    .fifo_dout         (fifo_dout),
    .fifo_empty        (fifo_empty),
    .fifo_read         (fifo_read),
    .out_valid         (out_valid),
    .out_data          (out_data),
    .timing_error      (timing_error),
    .timing_error_data (timing_error_data),
    .dispatch_count    (dispatch_count),
`ifdef RTI_DISPATCH_DROP_LATE_EN
    .drop_count        (drop_count),
`endif
    .busy              (busy)
  );

  typedef struct {
    logic [DW-1:0]  data;
    logic [TSW-1:0] cnt;
  } exp_out_t;

  exp_out_t      exp_out_q[$];
  logic [EW-1:0] exp_err_q[$];
  logic [EW-1:0] fifo_q[$];
  int            n_pass = 0;
  int            n_chk  = 0;
  int            rd_total = 0;
  int            rd_mark;
  bit            cnt_run = 1'b0;

  task automatic chk(input string tag, input logic [EW-1:0] obs, input logic [EW-1:0] exp);
    n_chk++;
    assert (obs === exp) n_pass++;
    else $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
  endtask

  task automatic push(input logic [TSW-1:0] ts, input logic [DW-1:0] d);
    fifo_q.push_back(rti_make_entry(ts, d));
    fifo_empty = 1'b0;
  endtask

  task automatic exp_out(input logic [DW-1:0] d, input logic [TSW-1:0] c);
    exp_out_t e;
    e.data = d;
    e.cnt  = c;
    exp_out_q.push_back(e);
  endtask

  // One clock: check outputs mid-cycle, then advance the FIFO model and timer.
  task automatic tick();
    logic     rd;
    exp_out_t e;
    @(negedge clk);
    rd = fifo_read;
    if (rd === 1'b1) rd_total++;
    if (reset || flush || !enable || fifo_empty) chk("no_read", EW'(fifo_read), EW'(0));
    if (out_valid === 1'b1) begin
      if (exp_out_q.size() == 0) chk("unexpected_strobe", EW'(out_valid), EW'(0));
      else begin
        e = exp_out_q.pop_front();
        chk("out_data", EW'(out_data), EW'(e.data));
        chk("strobe_time", EW'(counter), EW'(e.cnt));
      end
    end else if (out_valid !== 1'b0) chk("out_valid_known", EW'(out_valid), EW'(0));
    if (timing_error === 1'b1) begin
      if (exp_err_q.size() == 0) chk("unexpected_error", EW'(timing_error), EW'(0));
      else chk("timing_error_data", timing_error_data, exp_err_q.pop_front());
    end else if (timing_error !== 1'b0) chk("timing_error_known", EW'(timing_error), EW'(0));
    @(posedge clk);
    #1;
    if (rd === 1'b1 && fifo_q.size() > 0) fifo_dout = fifo_q.pop_front();
    else fifo_dout = {$urandom, $urandom, $urandom, $urandom};
    fifo_empty = (fifo_q.size() == 0);
    if (cnt_run) counter = counter + 1;
  endtask

  task automatic run(input int n);
    repeat (n) tick();
  endtask

  task automatic do_flush();
    flush = 1'b1;
    tick();
    flush = 1'b0;
  endtask

  initial begin
    reset = 1'b1; flush = 1'b0; enable = 1'b1; counter = '0;
    fifo_empty = 1'b1; fifo_dout = '0;
    push(64'd100, 64'hA5);
    @(posedge clk);
    #1;
    // 1: reset held with a non-empty FIFO
    run(3);
    chk("rst_out_valid", EW'(out_valid), EW'(0));
    chk("rst_out_data", EW'(out_data), EW'(0));
    chk("rst_timing_error", EW'(timing_error), EW'(0));
    chk("rst_err_data", timing_error_data, EW'(0));
    chk("rst_dispatch_count", EW'(dispatch_count), EW'(0));
    chk("rst_busy", EW'(busy), EW'(0));
    chk("rst_fifo_read", EW'(fifo_read), EW'(0));
`ifdef RTI_DISPATCH_DROP_LATE_EN
    chk("rst_drop_count", EW'(drop_count), EW'(0));
`endif

    // 2: ts=100 fetched at counter 0, strobe seen while counter is 101
    reset = 1'b0; cnt_run = 1'b1; rd_total = 0;
    exp_out(64'hA5, 64'd101);
    run(110);
    chk("t2_reads", EW'(rd_total), EW'(1));
    chk("t2_dispatch_count", EW'(dispatch_count), EW'(1));
    chk("t2_busy", EW'(busy), EW'(0));

    // 3: ts=5 with the timer frozen at 50
    cnt_run = 1'b0; counter = 64'd50;
    push(64'd5, 64'h5555_0000_1234_ABCD);
    exp_err_q.push_back({64'd5, 64'h5555_0000_1234_ABCD});
`ifndef RTI_DISPATCH_DROP_LATE_EN
    exp_out(64'h5555_0000_1234_ABCD, 64'd50);
`endif
    run(8);
    chk("t3_err_data_held", timing_error_data, {64'd5, 64'h5555_0000_1234_ABCD});
`ifdef RTI_DISPATCH_DROP_LATE_EN
    chk("t3_dispatch_count", EW'(dispatch_count), EW'(1));
    chk("t3_drop_count", EW'(drop_count), EW'(1));
`else
    chk("t3_dispatch_count", EW'(dispatch_count), EW'(2));
`endif

    // 4a: back-to-back ts=10,12 preloaded
    push(64'd10, 64'h1010);
    push(64'd12, 64'h1212);
    do_flush();
    chk("t4_flush_count", EW'(dispatch_count), EW'(0));
    chk("t4_flush_err_data", timing_error_data, EW'(0));
    counter = '0; cnt_run = 1'b1;
    exp_out(64'h1010, 64'd11);
    exp_out(64'h1212, 64'd13);
    run(20);
    chk("t4a_dispatch_count", EW'(dispatch_count), EW'(2));
    chk("t4a_no_error", timing_error_data, EW'(0));

    // 4b: ts=10,11 -> second is late (its first ARMED cycle sees 12)
    cnt_run = 1'b0;
    push(64'd10, 64'h2010);
    push(64'd11, 64'h2011);
    do_flush();
    counter = '0; cnt_run = 1'b1;
    exp_out(64'h2010, 64'd11);
    exp_err_q.push_back({64'd11, 64'h2011});
`ifndef RTI_DISPATCH_DROP_LATE_EN
    exp_out(64'h2011, 64'd13);
`endif
    run(20);
`ifdef RTI_DISPATCH_DROP_LATE_EN
    chk("t4b_dispatch_count", EW'(dispatch_count), EW'(1));
    chk("t4b_drop_count", EW'(drop_count), EW'(1));
`else
    chk("t4b_dispatch_count", EW'(dispatch_count), EW'(2));
`endif

    // 5: flush while ARMED on ts=1000 at counter 500
    cnt_run = 1'b0;
    push(64'd1000, 64'h3000);
    do_flush();
    counter = 64'd495; cnt_run = 1'b1;
    run(5);
    chk("t5_armed_busy", EW'(busy), EW'(1));
    chk("t5_counter", EW'(counter), EW'(500));
    push(64'd2000, 64'h4000);
    do_flush();
    enable = 1'b0;
    chk("t5_busy", EW'(busy), EW'(0));
    chk("t5_dispatch_count", EW'(dispatch_count), EW'(0));
    rd_mark = rd_total;
    run(520);
    chk("t5_no_reads", EW'(rd_total), EW'(rd_mark));
    chk("t5_dispatch_after", EW'(dispatch_count), EW'(0));

    // 6: enable dropped while ARMED still fires; then empty FIFO with enable high
    cnt_run = 1'b0;
    fifo_q.delete();
    push(64'd20, 64'h6020);
    do_flush();
    counter = '0; cnt_run = 1'b1; enable = 1'b1;
    exp_out(64'h6020, 64'd21);
    run(3);
    chk("t6_armed", EW'(busy), EW'(1));
    enable = 1'b0;
    run(25);
    chk("t6_dispatch_count", EW'(dispatch_count), EW'(1));
    enable = 1'b1;
    rd_mark = rd_total;
    run(100);
    chk("t6_empty_no_reads", EW'(rd_total), EW'(rd_mark));
    chk("t6_busy", EW'(busy), EW'(0));

    chk("pending_strobes", EW'(exp_out_q.size()), EW'(0));
    chk("pending_errors", EW'(exp_err_q.size()), EW'(0));
    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
